// File: rtl/dpwm.sv
// ---------------------------------------------------------------------------
// dpwm : digital PWM for a complementary high-side / low-side gate pair.
//   A free-running period counter compares against shadowed on-time and
//   dead-time settings. Shadows are refreshed only while idle or at the
//   period wrap, so mid-period input changes take effect at the next period.
//   Optional feature macro: DPWM_SYNC_OUT_EN adds the o_sync period strobe.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module dpwm #(
  parameter int PERIOD = 1000
) (
  input  logic        i_clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [10:0] i_ton,
  input  logic [4:0]  i_dt1,
  input  logic [4:0]  i_dt2,
  output logic        c1,
  output logic        c2
`ifdef DPWM_SYNC_OUT_EN
  ,
  output logic        o_sync
`endif
);

  localparam logic [11:0] PERIOD_W = 12'(PERIOD);
  localparam logic [10:0] CNT_LAST = 11'(PERIOD - 1);

  logic [10:0] cnt_q, cnt_d;
  logic [10:0] ton_q, ton_d;
  logic [4:0]  dt1_q, dt1_d;
  logic [4:0]  dt2_q, dt2_d;
  logic        c1_q, c1_d;
  logic        c2_q, c2_d;
  logic        wrap, load;
  logic [10:0] ton_clamp;
  logic [11:0] c2_start;

  // Next-state logic: counter, shadow refresh and gate decisions made from
  // the next counter/shadow values so the registered outputs line up with cnt.
  always_comb begin
    wrap      = (cnt_q == CNT_LAST);
    load      = !enable || wrap;
    // i_ton is at most 2047, so the clamped value always fits 11 bits.
    ton_clamp = ({1'b0, i_ton} > PERIOD_W) ? PERIOD_W[10:0] : i_ton;

    ton_d = load ? ton_clamp : ton_q;
    dt1_d = load ? i_dt1     : dt1_q;
    dt2_d = load ? i_dt2     : dt2_q;

    if (!enable || wrap) cnt_d = '0;
    else                 cnt_d = cnt_q + 11'd1;

    // Sum kept in 12 bits so a large ton+dt2 never wraps into a short window.
    c2_start = {1'b0, ton_d} + {7'b0, dt2_d};

    // c1 window ends at ton, c2 window starts at ton+dt2 >= ton: disjoint.
    c1_d = enable && ({6'b0, dt1_d} <= cnt_d) && (cnt_d < ton_d);
    c2_d = enable && (c2_start <= {1'b0, cnt_d}) && ({1'b0, cnt_d} < PERIOD_W);
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      ton_q <= '0;
      dt1_q <= '0;
      dt2_q <= '0;
      c1_q  <= 1'b0;
      c2_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ton_q <= ton_d;
      dt1_q <= dt1_d;
      dt2_q <= dt2_d;
      c1_q  <= c1_d;
      c2_q  <= c2_d;
    end
  end

  assign c1 = c1_q;
  assign c2 = c2_q;

`ifdef DPWM_SYNC_OUT_EN
  // Period-start strobe: high for the whole cnt==0 cycle while running.
  assign o_sync = reset && enable && (cnt_q == 11'd0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_dpwm.sv
// ---------------------------------------------------------------------------
// tb_dpwm : directed self-checking bench for dpwm (PERIOD = 1000).
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dpwm;

  localparam int PERIOD = 1000;

  logic        i_clk;
  logic        reset;
  logic        enable;
  logic [10:0] i_ton;
  logic [4:0]  i_dt1;
  logic [4:0]  i_dt2;
  logic        c1;
  logic        c2;
`ifdef DPWM_SYNC_OUT_EN
  logic        o_sync;
`endif

  int total = 0;
  int bad   = 0;
  int p     = 0;   // bench's own view of the period position
  int s1n, s1f, s1l, s2n, s2f, s2l;

  dpwm #(.PERIOD(PERIOD)) dut (
`ifdef DPWM_SYNC_OUT_EN
    .o_sync (o_sync),
`endif
    .i_clk  (i_clk),
    .reset  (reset),
    .enable (enable),
    .i_ton  (i_ton),
    .i_dt1  (i_dt1),
    .i_dt2  (i_dt2),
    .c1     (c1),
    .c2     (c2)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d (p=%0d)", tag, got, exp, p);
    end
  endtask

  // Advance to the next falling edge; position follows the enable seen at the rising edge.
  task automatic tick();
    @(negedge i_clk);
    if (enable) p = (p == PERIOD - 1) ? 0 : p + 1;
    else        p = 0;
    chk("no_overlap", {31'b0, c1 & c2}, 32'd0);
  endtask

  task automatic record();
    if (c1) begin if (s1f < 0) s1f = p; s1l = p; s1n++; end
    if (c2) begin if (s2f < 0) s2f = p; s2l = p; s2n++; end
  endtask

  // Observe one full period starting at p==0; optionally change i_ton at chg_at.
  task automatic period(input int chg_at, input logic [10:0] new_ton);
    s1n = 0; s1f = -1; s1l = -1; s2n = 0; s2f = -1; s2l = -1;
    record();
    repeat (PERIOD - 1) begin
      tick();
      if (p == chg_at) i_ton = new_ton;
      record();
    end
    tick();
  endtask

  task automatic check_stats(input string tag, input int e1n, input int e1f, input int e1l,
                             input int e2n, input int e2f, input int e2l);
    chk({tag, "_c1_count"}, s1n, e1n);
    chk({tag, "_c1_first"}, s1f, e1f);
    chk({tag, "_c1_last"},  s1l, e1l);
    chk({tag, "_c2_count"}, s2n, e2n);
    chk({tag, "_c2_first"}, s2f, e2f);
    chk({tag, "_c2_last"},  s2l, e2l);
  endtask

  initial begin
    // Reset state
    reset = 1'b0; enable = 1'b0; i_ton = 11'd680; i_dt1 = 5'd8; i_dt2 = 5'd10;
    #12;
    chk("rst_c1", {31'b0, c1}, 32'd0);
    chk("rst_c2", {31'b0, c2}, 32'd0);
`ifdef DPWM_SYNC_OUT_EN
    chk("rst_sync", {31'b0, o_sync}, 32'd0);
`endif
    @(negedge i_clk);
    reset = 1'b1;
    repeat (3) tick();
    chk("idle_c1", {31'b0, c1}, 32'd0);
    chk("idle_c2", {31'b0, c2}, 32'd0);

    // Start running: this cycle is p==0
    enable = 1'b1;
`ifdef DPWM_SYNC_OUT_EN
    #1 chk("sync_p0", {31'b0, o_sync}, 32'd1);
`endif
    period(-1, 11'd0);
    check_stats("nominal", 672, 8, 679, 310, 690, 999);

    // ton=1500 requested; this period still nominal
    i_ton = 11'd1500;
    period(-1, 11'd0);
    check_stats("hold", 672, 8, 679, 310, 690, 999);

    // Clamp period; request zero duty for the next
    i_ton = 11'd0;
    period(-1, 11'd0);
    check_stats("clamp", 992, 8, 999, 0, -1, -1);

    // Zero duty period; request nominal for the next
    i_ton = 11'd680;
    period(-1, 11'd0);
    check_stats("zero", 0, -1, -1, 990, 10, 999);

    // Mid-period update at p=400 leaves this period alone
    period(400, 11'd300);
    check_stats("midupd", 672, 8, 679, 310, 690, 999);
    period(-1, 11'd0);
    check_stats("after_upd", 292, 8, 299, 690, 310, 999);

    // ton below dt1: c1 suppressed
    i_ton = 11'd5;
    period(-1, 11'd0);
    i_ton = 11'd995;
    period(-1, 11'd0);
    check_stats("ton_lt_dt1", 0, -1, -1, 985, 15, 999);

    // ton+dt2 beyond the period: c2 suppressed
    i_ton = 11'd300;
    period(-1, 11'd0);
    check_stats("c2_over", 987, 8, 994, 0, -1, -1);

    // Drop enable mid-pulse at p=200
    repeat (200) tick();
    chk("en_pre_c1", {31'b0, c1}, 32'd1);
    enable = 1'b0;
    tick();
    chk("en_drop_c1", {31'b0, c1}, 32'd0);
    chk("en_drop_c2", {31'b0, c2}, 32'd0);
    repeat (3) tick();
    chk("en_idle_c1", {31'b0, c1}, 32'd0);

    // Async reset mid-pulse, between clock edges
    enable = 1'b1;
    repeat (100) tick();
    chk("rst_pre_c1", {31'b0, c1}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rst_async_c1", {31'b0, c1}, 32'd0);
    chk("rst_async_c2", {31'b0, c2}, 32'd0);
`ifdef DPWM_SYNC_OUT_EN
    chk("rst_async_sync", {31'b0, o_sync}, 32'd0);
`endif
    enable = 1'b0;
    i_ton  = 11'd680;
    @(negedge i_clk);
    reset = 1'b1;
    p = 0;
    repeat (3) tick();
    chk("post_rst_c1", {31'b0, c1}, 32'd0);
    chk("post_rst_c2", {31'b0, c2}, 32'd0);
    enable = 1'b1;
    period(-1, 11'd0);
    check_stats("post_rst", 672, 8, 679, 310, 690, 999);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
